// File: rtl/adc_decim_avg_if.sv
// adc_decim_avg_if: sample input and averaged-result handshake bundle for adc_decim_avg.
interface adc_decim_avg_if;
  logic [11:0] ad_data_ch0, ad_data_ch1, out_data_ch0, out_data_ch1;
  logic in_valid, out_valid, out_ready;
  modport master (output ad_data_ch0, ad_data_ch1, in_valid, out_ready,
                  input out_data_ch0, out_data_ch1, out_valid);
  modport slave (input ad_data_ch0, ad_data_ch1, in_valid, out_ready,
                 output out_data_ch0, out_data_ch1, out_valid);
endinterface

// File: rtl/adc_decim_avg.sv
// adc_decim_avg: two-channel block-average decimator (R = 2^decim_log2) with an output FIFO.
// Define ADC_TWOS_COMP_EN for signed two's-complement arithmetic; offset-binary unsigned otherwise.
module adc_decim_avg #(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_LOG2 = 6
) (
  input  logic           sys_clk,
  input  logic           rst_n,
  input  logic           enable,
  input  logic [2:0]     decim_log2,
  input  logic           ovf_clr,
  output logic           overflow,
  adc_decim_avg_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [2:0] MAXL = 3'(MAX_LOG2);
  logic [17:0] r_acc0, r_acc1, r_s1_sum0, r_s1_sum1;
  logic [5:0]  r_cnt;
  logic [2:0]  r_l2, r_s1_l2;
  logic        r_s1_v;
  logic [23:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr, r_rd;
  logic [17:0] w_x0, w_x1, w_sum0, w_sum1;
  logic [11:0] w_q0, w_q1;
  logic [2:0]  w_l2;
  logic [5:0]  w_mask;
  logic        w_acc, w_last, w_full, w_push, w_pop, w_wr;
`ifdef ADC_TWOS_COMP_EN
  assign w_x0 = 18'($signed({~bus.ad_data_ch0[11], bus.ad_data_ch0[10:0]}));
  assign w_x1 = 18'($signed({~bus.ad_data_ch1[11], bus.ad_data_ch1[10:0]}));
  assign w_q0 = 12'($signed(r_s1_sum0) >>> r_s1_l2);
  assign w_q1 = 12'($signed(r_s1_sum1) >>> r_s1_l2);
`else
  assign w_x0 = 18'(bus.ad_data_ch0);
  assign w_x1 = 18'(bus.ad_data_ch1);
  assign w_q0 = 12'(r_s1_sum0 >> r_s1_l2);
  assign w_q1 = 12'(r_s1_sum1 >> r_s1_l2);
`endif
  // The ratio is sampled on the first pair of a block and held until the block completes.
  assign w_acc  = bus.in_valid & enable;
  assign w_l2   = (r_cnt == '0) ? ((decim_log2 > MAXL) ? MAXL : decim_log2) : r_l2;
  assign w_mask = 6'((7'd1 << w_l2) - 7'd1);
  assign w_last = r_cnt == w_mask;
  assign w_sum0 = r_acc0 + w_x0;
  assign w_sum1 = r_acc1 + w_x1;
  assign w_full = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_push = r_s1_v;
  assign w_pop  = bus.out_valid & bus.out_ready;
  assign w_wr   = w_push & (~w_full | w_pop);
  assign bus.out_valid    = r_wr != r_rd;
  assign bus.out_data_ch0 = bus.out_valid ? r_mem[r_rd[AW-1:0]][11:0] : '0;
  assign bus.out_data_ch1 = bus.out_valid ? r_mem[r_rd[AW-1:0]][23:12] : '0;
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      r_acc0    <= '0;
      r_acc1    <= '0;
      r_cnt     <= '0;
      r_l2      <= '0;
      r_s1_v    <= 1'b0;
      r_s1_sum0 <= '0;
      r_s1_sum1 <= '0;
      r_s1_l2   <= '0;
      r_wr      <= '0;
      r_rd      <= '0;
      overflow  <= 1'b0;
    end else begin
      r_s1_v <= w_acc & w_last;
      if (w_acc & w_last) begin
        r_s1_sum0 <= w_sum0;
        r_s1_sum1 <= w_sum1;
        r_s1_l2   <= w_l2;
      end
      if (w_acc) r_l2 <= w_l2;
      if (!enable || (w_acc && w_last)) begin
        r_acc0 <= '0;
        r_acc1 <= '0;
        r_cnt  <= '0;
      end else if (w_acc) begin
        r_acc0 <= w_sum0;
        r_acc1 <= w_sum1;
        r_cnt  <= r_cnt + 6'd1;
      end
      if (w_wr) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      overflow <= (w_push & w_full & ~w_pop) | (overflow & ~ovf_clr);
    end
  always_ff @(posedge sys_clk)
    if (w_wr) r_mem[r_wr[AW-1:0]] <= {w_q1, w_q0};
endmodule

// File: tb/tb_adc_decim_avg.sv
// tb_adc_decim_avg: randomized and directed checks of adc_decim_avg against a queue-based average model.
module tb_adc_decim_avg;
  localparam int DEPTH = 4;
`ifdef ADC_TWOS_COMP_EN
  localparam logic [11:0] TM = 12'h800;
`else
  localparam logic [11:0] TM = 12'h000;
`endif
  logic sys_clk = 0, rst_n = 0, enable = 0, ovf_clr = 0, overflow;
  logic [2:0] decim_log2 = 0;
  int errors = 0, checks = 0;
  int m_s0, m_s1, m_n, m_l2;
  logic [23:0] m_q[$];
  logic [23:0] m_pend;
  logic m_pv, m_ovf;
  adc_decim_avg_if bus();
  adc_decim_avg #(.FIFO_DEPTH(DEPTH), .MAX_LOG2(6)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .enable(enable), .decim_log2(decim_log2),
    .ovf_clr(ovf_clr), .overflow(overflow), .bus(bus));
  always #5 sys_clk = ~sys_clk;
  function automatic int conv(input logic [11:0] d);
`ifdef ADC_TWOS_COMP_EN
    return int'(d) - 2048;
`else
    return int'(d);
`endif
  endfunction
  task automatic model_reset;
    m_s0 = 0; m_s1 = 0; m_n = 0; m_l2 = 0;
    m_q.delete(); m_pv = 0; m_ovf = 0; m_pend = '0;
  endtask
  // Drive one cycle of inputs, advance the model across the edge, return 1 time unit after it.
  task automatic cycle(input logic v, input logic [11:0] d0, input logic [11:0] d1, input logic en,
                       input logic [2:0] l2, input logic rdy, input logic clr);
    logic pop, set;
    bus.in_valid = v; bus.ad_data_ch0 = d0; bus.ad_data_ch1 = d1;
    enable = en; decim_log2 = l2; bus.out_ready = rdy; ovf_clr = clr;
    pop = (m_q.size() != 0) && rdy;
    set = 0;
    if (pop) void'(m_q.pop_front());
    if (m_pv) begin
      if (m_q.size() < DEPTH) m_q.push_back(m_pend);
      else set = 1;
    end
    m_ovf = set | (m_ovf & !clr);
    m_pv = 0;
    if (!en) begin
      m_s0 = 0; m_s1 = 0; m_n = 0;
    end else if (v) begin
      if (m_n == 0) m_l2 = (l2 > 6) ? 6 : int'(l2);
      m_s0 += conv(d0); m_s1 += conv(d1); m_n++;
      if (m_n == (1 << m_l2)) begin
        m_pend = {12'(m_s1 >>> m_l2), 12'(m_s0 >>> m_l2)};
        m_pv = 1; m_s0 = 0; m_s1 = 0; m_n = 0;
      end
    end
    @(posedge sys_clk); #1;
  endtask
  task automatic test_reset;
    rst_n = 0; bus.in_valid = 0; bus.ad_data_ch0 = 0; bus.ad_data_ch1 = 0; bus.out_ready = 0;
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
    checks++; if ({bus.out_data_ch1, bus.out_data_ch0} !== 24'h0) begin errors++; $display("FAIL reset_data got %h want 0", {bus.out_data_ch1, bus.out_data_ch0}); end
    rst_n = 1;
  endtask
  task automatic test_avg4;
    int v[4] = '{100, 200, 300, 400};
    for (int i = 0; i < 4; i++) cycle(1, 12'(v[i]), 12'd7, 1, 3'd2, 1, 0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL avg4_early got %b want 0", bus.out_valid); end
    cycle(0, 0, 0, 1, 3'd2, 1, 0);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL avg4_valid got %b want 1", bus.out_valid); end
    checks++; if (bus.out_data_ch0 !== (12'd250 ^ TM)) begin errors++; $display("FAIL avg4_ch0 got %h want %h", bus.out_data_ch0, 12'd250 ^ TM); end
    checks++; if (bus.out_data_ch1 !== (12'd7 ^ TM)) begin errors++; $display("FAIL avg4_ch1 got %h want %h", bus.out_data_ch1, 12'd7 ^ TM); end
    cycle(0, 0, 0, 1, 3'd2, 1, 0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL avg4_single got %b want 0", bus.out_valid); end
  endtask
  task automatic test_twos;
`ifdef ADC_TWOS_COMP_EN
    logic [11:0] exp1 = 12'h801;
`else
    logic [11:0] exp1 = 12'h001;
`endif
    cycle(1, 12'h010, 12'h000, 1, 3'd1, 1, 0);
    cycle(1, 12'h020, 12'h002, 1, 3'd1, 1, 0);
    cycle(0, 0, 0, 1, 3'd1, 1, 0);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL twos_valid got %b want 1", bus.out_valid); end
    checks++; if (bus.out_data_ch1 !== exp1) begin errors++; $display("FAIL twos_ch1 got %h want %h", bus.out_data_ch1, exp1); end
    checks++; if (bus.out_data_ch0 !== (12'h018 ^ TM)) begin errors++; $display("FAIL twos_ch0 got %h want %h", bus.out_data_ch0, 12'h018 ^ TM); end
    cycle(0, 0, 0, 1, 3'd1, 1, 0);
  endtask
  task automatic test_overflow;
    for (int i = 0; i < 5; i++) cycle(1, 12'(10 + i), 12'(20 + i), 1, 3'd0, 0, 0);
    cycle(0, 0, 0, 1, 3'd0, 0, 0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data_ch0 !== (12'(10 + i) ^ TM))
        begin errors++; $display("FAIL ovf_drain%0d got v=%b d=%h want v=1 d=%h", i, bus.out_valid, bus.out_data_ch0, 12'(10 + i) ^ TM); end
      cycle(0, 0, 0, 1, 3'd0, 1, 0);
    end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b want 0", bus.out_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    cycle(0, 0, 0, 1, 3'd0, 0, 1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b want 0", overflow); end
    for (int i = 0; i < 5; i++) cycle(1, 12'(30 + i), 0, 1, 3'd0, 0, 0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_pre got %b want 0", overflow); end
    cycle(0, 0, 0, 1, 3'd0, 0, 1);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_setwins got %b want 1", overflow); end
    checks++; if (bus.out_data_ch0 !== (12'd30 ^ TM)) begin errors++; $display("FAIL ovf_head got %h want %h", bus.out_data_ch0, 12'd30 ^ TM); end
    repeat (4) cycle(0, 0, 0, 1, 3'd0, 1, 1);
    checks++; if (bus.out_valid !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_final got v=%b o=%b want 0 0", bus.out_valid, overflow); end
  endtask
  task automatic test_ratio_change;
    for (int k = 1; k <= 8; k++) begin
      cycle(1, 12'(8 * k), 12'd100, 1, (k <= 2) ? 3'd3 : 3'd1, 1, 0);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ratio_early%0d got %b want 0", k, bus.out_valid); end
    end
    cycle(0, 0, 0, 1, 3'd1, 1, 0);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data_ch0 !== (12'd36 ^ TM))
      begin errors++; $display("FAIL ratio_blk8 got v=%b d=%h want v=1 d=%h", bus.out_valid, bus.out_data_ch0, 12'd36 ^ TM); end
    cycle(1, 12'd1000, 12'd100, 1, 3'd1, 1, 0);
    cycle(1, 12'd2000, 12'd100, 1, 3'd1, 1, 0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ratio_gap got %b want 0", bus.out_valid); end
    cycle(0, 0, 0, 1, 3'd1, 1, 0);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data_ch0 !== (12'd1500 ^ TM))
      begin errors++; $display("FAIL ratio_blk2 got v=%b d=%h want v=1 d=%h", bus.out_valid, bus.out_data_ch0, 12'd1500 ^ TM); end
    cycle(0, 0, 0, 1, 3'd1, 1, 0);
  endtask
  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) cycle(1, 12'(50 + i), 0, 1, 3'd0, 0, 0);
    cycle(1, 12'd4000, 0, 1, 3'd2, 0, 0);
    cycle(1, 12'd4000, 0, 1, 3'd2, 0, 0);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %b want 1", bus.out_valid); end
    #1 rst_n = 0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_async got %b want 0", bus.out_valid); end
    model_reset();
    #1 rst_n = 1;
    cycle(1, 12'd1000, 0, 1, 3'd2, 1, 0);
    cycle(1, 12'd1000, 0, 1, 3'd2, 1, 0);
    cycle(1, 12'd3000, 0, 1, 3'd2, 1, 0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_early got %b want 0", bus.out_valid); end
    cycle(1, 12'd3000, 0, 1, 3'd2, 1, 0);
    cycle(0, 0, 0, 1, 3'd2, 1, 0);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data_ch0 !== (12'd2000 ^ TM))
      begin errors++; $display("FAIL rstmid_blk got v=%b d=%h want v=1 d=%h", bus.out_valid, bus.out_data_ch0, 12'd2000 ^ TM); end
    cycle(0, 0, 0, 1, 3'd2, 1, 0);
  endtask
  task automatic test_enable;
    for (int i = 0; i < 5; i++) cycle(1, 12'd4000, 12'd5, 1, 3'd3, 1, 0);
    repeat (2) cycle(1, 12'd4000, 12'd5, 0, 3'd3, 1, 0);
    for (int k = 1; k <= 8; k++) begin
      cycle(1, 12'(10 * k), 12'd5, 1, 3'd3, 1, 0);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL en_early%0d got %b want 0", k, bus.out_valid); end
    end
    cycle(0, 0, 0, 1, 3'd3, 1, 0);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data_ch0 !== (12'd45 ^ TM) || bus.out_data_ch1 !== (12'd5 ^ TM))
      begin errors++; $display("FAIL en_blk got v=%b d=%h/%h want v=1 d=%h/%h", bus.out_valid, bus.out_data_ch0, bus.out_data_ch1, 12'd45 ^ TM, 12'd5 ^ TM); end
    cycle(0, 0, 0, 1, 3'd3, 1, 0);
  endtask
  task automatic test_random;
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0, 12'($urandom), 12'($urandom), $urandom_range(0, 19) != 0,
            ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 2)), $urandom_range(0, 2) != 0,
            $urandom_range(0, 7) == 0);
      checks++; if (bus.out_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_valid@%0d got %b want %b", i, bus.out_valid, m_q.size() != 0); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf@%0d got %b want %b", i, overflow, m_ovf); end
      if (m_q.size() != 0) begin
        checks++; if ({bus.out_data_ch1, bus.out_data_ch0} !== m_q[0])
          begin errors++; $display("FAIL rnd_data@%0d got %h want %h", i, {bus.out_data_ch1, bus.out_data_ch0}, m_q[0]); end
      end
    end
  endtask
  initial begin
    test_reset();
    test_avg4();
    test_twos();
    test_overflow();
    test_ratio_change();
    test_reset_mid();
    test_enable();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/adc_decim_avg.md
ADC_DECIM_AVG -- requirements
Module: adc_decim_avg

Interface
REQ-001 The block SHALL take parameter FIFO_DEPTH, default 4, as the output FIFO depth in entries (power of two, at least 2).
REQ-002 The block SHALL take parameter MAX_LOG2, default 6, as the largest decimation exponent supported.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset:
- sys_clk  in  1  system clock, the same clock as the ADC capture stage.
- rst_n  in  1  asynchronous active-low reset.
REQ-004 The block SHALL have these ports:
- ad_data_ch0  in  12  channel 0 sample, offset binary, valid every cycle.
- ad_data_ch1  in  12  channel 1 sample, offset binary.
- in_valid  in  1  both samples valid this cycle.
- enable  in  1  0 holds and clears the accumulators.
- decim_log2  in  3  decimation ratio R = 2^decim_log2; values above MAX_LOG2 are clamped to MAX_LOG2.
- out_data_ch0  out  12  channel 0 averaged sample.
- out_data_ch1  out  12  channel 1 averaged sample.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head.
- overflow  out  1  sticky flag: a block result was dropped.
- ovf_clr  in  1  clears overflow.

Function
REQ-005 The block SHALL accept a sample pair on every sys_clk edge where in_valid=1 and enable=1.
REQ-006 The block SHALL add accepted samples into two 18-bit accumulators and count accepted pairs in a 6-bit counter.
REQ-007 The block SHALL latch decim_log2 at the first accepted pair of each block; changes in mid-block take effect at the next block.
REQ-008 When the pair that completes a block of R samples is accepted, the block SHALL form result = (acc + sample) >> decim_log2 (truncate) and restart the accumulators at 0.
REQ-009 The block SHALL make out_valid high 2 cycles after the completing pair is accepted, provided the FIFO was empty.
REQ-010 With R=1 the block SHALL pass every accepted sample through unchanged at 2-cycle latency.
REQ-011 Output handshake: the FIFO head SHALL pop on the edge where out_valid=1 and out_ready=1. out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-012 FIFO boundaries:
- The FIFO SHALL accept a push and a pop in the same cycle while full.
- A push into an empty FIFO SHALL not be visible at the head until the next cycle.
- A completed result that finds the FIFO full with no pop in that cycle SHALL be dropped, set overflow, and leave FIFO contents unchanged.
REQ-013 The overflow flag SHALL clear on ovf_clr=1. If set and clear happen in the same cycle, set SHALL win.
REQ-014 When enable=0, the block SHALL clear the accumulators and counter, accept no samples, and keep FIFO contents and the output handshake running.
REQ-015 When enable rises, the first accepted pair SHALL start a new block.
REQ-016 The pipeline SHALL hold two pipeline stages: accumulate, then shift and FIFO write.

Reset
REQ-017 Asserting rst_n=0 SHALL, asynchronously, clear the accumulators, counter, latched ratio, pipeline valid bits, FIFO pointers and overflow. After reset, out_valid=0, overflow=0, out_data=0.
REQ-018 Reset asserted mid-block SHALL discard the partial block and all FIFO contents.

Configuration
REQ-019 Macro ADC_TWOS_COMP_EN:
- Defined: each input SHALL be converted to two's complement (bit 11 inverted), the accumulators SHALL be signed with arithmetic shift, and the outputs SHALL be two's complement.
- Undefined: the block SHALL use unsigned offset-binary arithmetic throughout.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Undefined macro, decim_log2=2, inputs 100,200,300,400 on ch0 -> one output 250, out_valid 2 cycles after the 4th sample.
- Defined macro, decim_log2=1, ch1 inputs 0x000,0x002 -> output 0x801, i.e. (-2048 + -2046) / 2.
- decim_log2=0, out_ready=0, FIFO_DEPTH=4, 5 samples -> 4 entries held, overflow=1, 5th sample dropped. Then ovf_clr=1 with a simultaneous overflow event -> overflow stays 1.
- decim_log2 changed from 3 to 1 after 2 samples of a block -> current block completes at 8 samples, next block at 2 samples.
- rst_n pulsed low mid-block with 3 FIFO entries -> out_valid=0 at once. The next block restarts at count 0.
- enable dropped after 5 of 8 samples, then raised -> no partial output, next output averages 8 new samples.
